// File: rtl/uart_cmd_assembler_pkg.sv
// Shared types and constants for the UART command assembler.
// Frame length follows UART_CMD_CHECKSUM_EN (4 nibbles when defined, otherwise 3).
package uart_pkg;

    localparam int CLKS_PER_BIT = 5208;
    localparam int NIB_W        = 4;

`ifdef UART_CMD_CHECKSUM_EN
    localparam int FRAME_NIBS = 4;
`else
    localparam int FRAME_NIBS = 3;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT_OP = 2'd1,
        GOT_A  = 2'd2,
        GOT_B  = 2'd3
    } asm_state_t;

    // Checksum nibble carried as the last nibble of a checked frame.
    function automatic logic [NIB_W-1:0] chk_nib(input logic [NIB_W-1:0] op,
                                                 input logic [NIB_W-1:0] a,
                                                 input logic [NIB_W-1:0] b);
        return op ^ a ^ b;
    endfunction

endpackage

// File: rtl/uart_cmd_assembler_timeout_cnt.sv
// Inter-nibble watchdog: counts idle clocks while enabled, flags the clock on
// which the count reaches TIMEOUT_CLKS-1 (combinational, one clock wide).
module uart_timeout_cnt #(
    parameter int TIMEOUT_CLKS = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // A clear in the same clock (new nibble) always beats expiry.
    assign expired = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles UART nibbles into op/A/B command frames with a one-deep holding register.
// UART_CMD_CHECKSUM_EN adds a fourth checksum nibble (op^a^b) and the err_chk pulse.
module uart_cmd_assembler
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 5_000_000,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NIB_W-1:0] nib_data,
    input  logic             nib_valid,
    output logic [NIB_W-1:0] cmd_op,
    output logic [NIB_W-1:0] cmd_a,
    output logic [NIB_W-1:0] cmd_b,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             err_chk,
    output logic             err_timeout,
    output logic             err_overflow,
    output logic [CNT_W-1:0] frame_count
);

    // Output handshake: a frame transfers on any clock where cmd_valid && cmd_ready;
    // while cmd_valid && !cmd_ready the held frame and cmd_valid do not change.

    asm_state_t       state, state_next;
    logic [NIB_W-1:0] op_q, a_q;
    logic [NIB_W-1:0] fin_b;
    logic             complete, chk_ok, expired, load;

`ifdef UART_CMD_CHECKSUM_EN
    logic [NIB_W-1:0] b_q;
    assign fin_b = b_q;
`else
    assign fin_b = nib_data;
`endif

    uart_timeout_cnt #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (nib_valid || (state == IDLE)),
        .enable (state != IDLE),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        complete   = 1'b0;
        chk_ok     = 1'b1;
        case (state)
            IDLE: begin
                if (nib_valid) state_next = GOT_OP;
            end
            GOT_OP: begin
                if (nib_valid)    state_next = GOT_A;
                else if (expired) state_next = IDLE;
            end
            GOT_A: begin
                if (nib_valid) begin
`ifdef UART_CMD_CHECKSUM_EN
                    state_next = GOT_B;
`else
                    state_next = IDLE;
                    complete   = 1'b1;
`endif
                end else if (expired) begin
                    state_next = IDLE;
                end
            end
            GOT_B: begin
`ifdef UART_CMD_CHECKSUM_EN
                if (nib_valid) begin
                    state_next = IDLE;
                    complete   = 1'b1;
                    chk_ok     = (nib_data == chk_nib(op_q, a_q, b_q));
                end else if (expired) begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    assign load = complete && chk_ok && (!cmd_valid || cmd_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q         <= '0;
            a_q          <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            b_q          <= '0;
`endif
            cmd_op       <= '0;
            cmd_a        <= '0;
            cmd_b        <= '0;
            cmd_valid    <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
            frame_count  <= '0;
        end else begin
            if (nib_valid) begin
                case (state)
                    IDLE:   op_q <= nib_data;
                    GOT_OP: a_q  <= nib_data;
`ifdef UART_CMD_CHECKSUM_EN
                    GOT_A:  b_q  <= nib_data;
`endif
                    default: ;
                endcase
            end
            err_timeout  <= expired;
            err_overflow <= complete && chk_ok && !load;
            if (load) begin
                cmd_op      <= op_q;
                cmd_a       <= a_q;
                cmd_b       <= fin_b;
                cmd_valid   <= 1'b1;
                frame_count <= frame_count + CNT_W'(1);
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

`ifdef UART_CMD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_chk <= 1'b0;
        end else begin
            err_chk <= complete && !chk_ok;
        end
    end
`else
    assign err_chk = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Bench for uart_cmd_assembler (TIMEOUT_CLKS=100): directed and random nibble
// streams compared every clock against a frame-level reference model.
module tb_uart_cmd_assembler;

    localparam int TMO   = 100;
    localparam int CNT_W = 8;
`ifdef UART_CMD_CHECKSUM_EN
    localparam int NIBS = 4;
`else
    localparam int NIBS = 3;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       nib_data = '0;
    logic             nib_valid = 1'b0;
    logic             cmd_ready = 1'b1;
    logic [3:0]       cmd_op, cmd_a, cmd_b;
    logic             cmd_valid, err_chk, err_timeout, err_overflow;
    logic [CNT_W-1:0] frame_count;

    uart_cmd_assembler #(.TIMEOUT_CLKS(TMO), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .nib_data    (nib_data),
        .nib_valid   (nib_valid),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .err_chk     (err_chk),
        .err_timeout (err_timeout),
        .err_overflow(err_overflow),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    bit rand_rdy = 1'b0;

    // Reference model: pending nibbles of the current frame, idle clocks since
    // the last nibble, and the frame currently offered to the consumer.
    logic [3:0]       part_q[$];
    int               idle_clks = 0;
    logic             m_valid = 1'b0;
    logic [3:0]       m_op = '0, m_a = '0, m_b = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_chk = 1'b0, m_to = 1'b0, m_ov = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit good;
        bit loaded;
        bit taken;
        if (reset) begin
            part_q.delete();
            idle_clks = 0;
            m_valid = 0; m_op = 0; m_a = 0; m_b = 0; m_cnt = 0;
            m_chk = 0; m_to = 0; m_ov = 0;
            return;
        end
        m_chk = 0; m_to = 0; m_ov = 0;
        loaded = 0;
        taken = m_valid && cmd_ready;
        if (nib_valid) begin
            part_q.push_back(nib_data);
            idle_clks = 0;
            if (part_q.size() == NIBS) begin
                good = (NIBS == 3) || (part_q[NIBS-1] == (part_q[0] ^ part_q[1] ^ part_q[2]));
                if (!good) begin
                    m_chk = 1;
                end else if (!m_valid || cmd_ready) begin
                    m_op = part_q[0]; m_a = part_q[1]; m_b = part_q[2];
                    m_valid = 1;
                    m_cnt = m_cnt + 1'b1;
                    loaded = 1;
                end else begin
                    m_ov = 1;
                end
                part_q.delete();
            end
        end else if (part_q.size() > 0) begin
            idle_clks++;
            if (idle_clks == TMO) begin
                m_to = 1;
                part_q.delete();
                idle_clks = 0;
            end
        end
        if (taken && !loaded) m_valid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("cmd_valid", cmd_valid, m_valid);
        chk("cmd_op", cmd_op, m_op);
        chk("cmd_a", cmd_a, m_a);
        chk("cmd_b", cmd_b, m_b);
        chk("err_chk", err_chk, m_chk);
        chk("err_timeout", err_timeout, m_to);
        chk("err_overflow", err_overflow, m_ov);
        chk("frame_count", frame_count, m_cnt);
        if (rand_rdy) cmd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_nib(input logic [3:0] d, input int gap);
        nib_data  = d;
        nib_valid = 1'b1;
        tick();
        nib_valid = 1'b0;
        nib_data  = 4'($urandom);
        repeat (gap) tick();
    endtask

    function automatic logic [3:0] last_nib(input logic [3:0] op, a, b);
        return (NIBS == 4) ? (op ^ a ^ b) : b;
    endfunction

    // Sends a full frame; the completing nibble is followed by `gap` idle clocks.
    task automatic send_frame(input logic [3:0] op, a, b, input int gap);
        send_nib(op, gap);
        send_nib(a, gap);
        if (NIBS == 4) send_nib(b, gap);
        send_nib(last_nib(op, a, b), gap);
    endtask

    initial begin
        logic [3:0] r_op, r_a, r_b;
        // Reset for two clocks.
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("reset_valid", cmd_valid, 1'b0);
        chk("reset_count", frame_count, '0);
        tick();

        // Basic frame at ~20-clock spacing, consumer always ready.
        cmd_ready = 1'b1;
        send_nib(4'h3, 19);
        send_nib(4'h5, 19);
        if (NIBS == 4) send_nib(4'h6, 19);
        send_nib(last_nib(4'h3, 4'h5, 4'h6), 0);
        chk("first_valid", cmd_valid, 1'b1);
        chk("first_op", cmd_op, 4'h3);
        chk("first_a", cmd_a, 4'h5);
        chk("first_b", cmd_b, 4'h6);
        chk("first_count", frame_count, 8'd1);
        repeat (5) tick();

`ifdef UART_CMD_CHECKSUM_EN
        // Bad checksum drops the frame; the next good one is accepted.
        send_nib(4'h3, 2); send_nib(4'h5, 2); send_nib(4'h6, 2);
        send_nib(4'hF, 0);
        chk("bad_chk_pulse", err_chk, 1'b1);
        chk("bad_chk_valid", cmd_valid, 1'b0);
        chk("bad_chk_count", frame_count, 8'd1);
        repeat (3) tick();
        send_frame(4'hA, 4'hB, 4'hC, 2);
`endif

        // Partial frame abandoned after TMO idle clocks, then 9 starts a new frame.
        send_nib(4'h3, 2);
        send_nib(4'h5, TMO - 1);
        tick();
        chk("timeout_pulse", err_timeout, 1'b1);
        repeat (5) tick();
        send_nib(4'h9, 1); send_nib(4'h1, 1);
        if (NIBS == 4) send_nib(4'h2, 1);
        send_nib(last_nib(4'h9, 4'h1, 4'h2), 0);
        chk("after_timeout_op", cmd_op, 4'h9);
        repeat (3) tick();

        // Overflow: consumer stalled, second frame dropped.
        cmd_ready = 1'b0;
        send_frame(4'h1, 4'h2, 4'h3, 1);
        send_nib(4'h4, 1); send_nib(4'h5, 1);
        if (NIBS == 4) send_nib(4'h6, 1);
        send_nib(last_nib(4'h4, 4'h5, 4'h6), 0);
        chk("overflow_pulse", err_overflow, 1'b1);
        chk("overflow_hold_op", cmd_op, 4'h1);
        chk("overflow_hold_b", cmd_b, 4'h3);
        repeat (4) tick();
        // Ready rises on the completing clock: the new frame replaces the old one.
        send_nib(4'h4, 1); send_nib(4'h5, 1);
        if (NIBS == 4) send_nib(4'h6, 1);
        cmd_ready = 1'b1;
        send_nib(last_nib(4'h4, 4'h5, 4'h6), 0);
        chk("late_ready_no_ovf", err_overflow, 1'b0);
        chk("late_ready_op", cmd_op, 4'h4);
        chk("late_ready_valid", cmd_valid, 1'b1);
        repeat (3) tick();

        // Mid-frame reset, then a clean frame.
        send_nib(4'h7, 1); send_nib(4'h8, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_valid", cmd_valid, 1'b0);
        chk("midreset_op", cmd_op, 4'h0);
        chk("midreset_count", frame_count, 8'd0);
        send_frame(4'hC, 4'hD, 4'hE, 1);
        chk("post_reset_count", frame_count, 8'd1);

        // Nibble on the exact timeout clock wins.
        send_nib(4'h2, 0);
        send_nib(4'h6, TMO - 1);
        if (NIBS == 4) send_nib(4'h1, 0);
        else begin
            send_nib(4'h1, 0);
            chk("edge_no_timeout", err_timeout, 1'b0);
        end
        if (NIBS == 4) begin
            chk("edge_no_timeout", err_timeout, 1'b0);
            send_nib(last_nib(4'h2, 4'h6, 4'h1), 0);
        end
        chk("edge_frame_op", cmd_op, 4'h2);
        repeat (3) tick();

        // Random frames with random consumer stalls and occasional corruption.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r_op = 4'($urandom); r_a = 4'($urandom); r_b = 4'($urandom);
            send_nib(r_op, $urandom_range(0, 3));
            send_nib(r_a, $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                repeat (TMO + 2) tick();
                continue;
            end
            if (NIBS == 4) begin
                send_nib(r_b, $urandom_range(0, 3));
                send_nib(($urandom_range(0, 5) == 0) ? 4'($urandom) : (r_op ^ r_a ^ r_b),
                         $urandom_range(0, 3));
            end else begin
                send_nib(r_b, $urandom_range(0, 3));
            end
        end
        rand_rdy = 1'b0;
        cmd_ready = 1'b1;
        repeat (3) tick();

        // 256 accepted frames wrap the counter back to zero.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            send_frame(4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 1));
        end
        repeat (2) tick();
        chk("wrap_count", frame_count, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
